// File: rtl/mac_out_fifo.sv
// mac_out_fifo
// ------------
// Output buffer that sits directly behind part2_mac. The MAC cannot be
// stalled, so this block captures every result on the cycle it is valid.
// It then hands the results to the next consumer in order, using a
// valid/ready handshake.
//
// Lost results are always recorded. If a result arrives while the queue is
// full and no read frees a slot in the same cycle, the result is dropped.
// Each drop sets a sticky overflow flag and bumps a saturating drop counter.
//
// The output is show-ahead: data_out always presents the head entry.
// A value written at edge k becomes visible in the cycle after edge k.
// There is no bypass from f_in to data_out while the queue is empty.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; wins over any coincident read/write
//   f_in       signed 24-bit accumulator value from the MAC
//   valid_in   f_in is valid this cycle
//   data_out   signed head-of-queue value (don't-care while valid_out=0)
//   valid_out  data_out holds a valid entry
//   ready_in   consumer accepts data_out this cycle
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   overflow   sticky; set when any valid_in is dropped
//   drop_cnt   number of dropped inputs, saturating at all-ones
//
// DEPTH must be a power of two and >= 2. The pointers rely on natural
// binary wrap at DEPTH.
module mac_out_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [23:0]         f_in,
    input  logic                       valid_in,
    output logic signed [23:0]         data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Storage is intentionally left uncleared by reset.
    logic [23:0]      mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             rd;
    logic             wr;
    logic             drop;

    assign valid_out = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign data_out  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // A write into a full queue still succeeds when a read frees the head
    // slot in the same cycle.
    assign rd   = valid_out & ready_in;
    assign wr   = valid_in & (~full | rd);
    assign drop = valid_in & full & ~rd;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr, rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // An input that arrives together with reset is not captured.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            mem_q[wr_ptr_q] <= f_in;
        end
    end

endmodule
